// File: rtl/level_tick_gen_pkg.sv
// level_tick_gen_pkg: shared level width, default divisors and level encodings for the tick path
package level_tick_gen_pkg;
  localparam int P_LEVEL = 2;
  localparam int DIV1 = 50_000_000;
  localparam int DIV2 = 25_000_000;
  localparam int DIV3 = 12_500_000;
  localparam int DIV4 = 6_250_000;
  typedef enum logic [P_LEVEL-1:0] {
    LVL_SLOW  = 2'd0,
    LVL_MED   = 2'd1,
    LVL_QUICK = 2'd2,
    LVL_FAST  = 2'd3
  } level_t;
endpackage

// File: rtl/level_tick_gen_tick_divider.sv
// tick_divider: one-cycle tick every DIV cycles; restart reloads the count without dropping a pending tick
// ports: clk, reset (sync, active-high), restart (counter to 0), tick (registered strobe)
module tick_divider #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic restart,
  output logic tick
);
  localparam int W = $clog2(DIV);
  localparam logic [W-1:0] LAST = W'(DIV - 1);
  logic [W-1:0] cnt;
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= cnt == LAST;
      cnt  <= (restart || cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end
endmodule

// File: rtl/level_tick_gen.sv
// level_tick_gen: level register with edge-triggered advance/clear plus four speed strobes cl1..cl4
// ports: clk, reset (sync, active-high), level_up (rising edge advances), level_clr (back to level 0, wins),
//        level (registered), cl1..cl4 (one-cycle strobes every DIVn cycles), level_chg (pulse on level change)
// build option: define LEVEL_WRAP_EN to wrap level 3 -> 0 instead of saturating
module level_tick_gen
  import level_tick_gen_pkg::*;
#(
  parameter int P_LEVEL = level_tick_gen_pkg::P_LEVEL,
  parameter int DIV1 = level_tick_gen_pkg::DIV1,
  parameter int DIV2 = level_tick_gen_pkg::DIV2,
  parameter int DIV3 = level_tick_gen_pkg::DIV3,
  parameter int DIV4 = level_tick_gen_pkg::DIV4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               level_up,
  input  logic               level_clr,
  output logic [P_LEVEL-1:0] level,
  output logic               cl1,
  output logic               cl2,
  output logic               cl3,
  output logic               cl4,
  output logic               level_chg
);
`ifdef LEVEL_WRAP_EN
  localparam logic WRAP = 1'b1;
`else
  localparam logic WRAP = 1'b0;
`endif
  logic               up_q;
  logic               up_rise;
  logic               chg;
  logic [P_LEVEL-1:0] next_level;
  always_comb begin
    up_rise    = level_up & ~up_q;
    next_level = level_clr ? P_LEVEL'(LVL_SLOW) :
                 !up_rise ? level :
                 level != P_LEVEL'(LVL_FAST) ? level + P_LEVEL'(1) :
                 WRAP ? P_LEVEL'(LVL_SLOW) : level;
    chg        = next_level != level;
  end
  // up_q always follows level_up, so an edge swallowed by a clear is still consumed
  always_ff @(posedge clk) begin
    if (reset) begin
      up_q      <= 1'b0;
      level     <= P_LEVEL'(LVL_SLOW);
      level_chg <= 1'b0;
    end else begin
      up_q      <= level_up;
      level     <= next_level;
      level_chg <= chg;
    end
  end
  // dividers reload on the same edge that loads the new level
  tick_divider #(.DIV(DIV1)) u_div1 (.clk(clk), .reset(reset), .restart(chg), .tick(cl1));
  tick_divider #(.DIV(DIV2)) u_div2 (.clk(clk), .reset(reset), .restart(chg), .tick(cl2));
  tick_divider #(.DIV(DIV3)) u_div3 (.clk(clk), .reset(reset), .restart(chg), .tick(cl3));
  tick_divider #(.DIV(DIV4)) u_div4 (.clk(clk), .reset(reset), .restart(chg), .tick(cl4));
endmodule

// File: tb/tb_level_tick_gen.sv
// tb_level_tick_gen: directed self-checking bench for level_tick_gen with DIV1..4 = 8,6,4,2
module tb_level_tick_gen;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       level_up = 1'b0;
  logic       level_clr = 1'b0;
  logic [1:0] level;
  logic       cl1, cl2, cl3, cl4, level_chg;
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  level_tick_gen #(.P_LEVEL(2), .DIV1(8), .DIV2(6), .DIV3(4), .DIV4(2)) dut (
    .clk(clk), .reset(reset), .level_up(level_up), .level_clr(level_clr),
    .level(level), .cl1(cl1), .cl2(cl2), .cl3(cl3), .cl4(cl4), .level_chg(level_chg)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // cycle 0 is the state right after the last edge that sampled reset high
  task automatic do_reset();
    reset = 1'b1;
    level_up = 1'b0;
    level_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    cyc = 0;
  endtask

  logic [17:0] m1, m2, m3, m4;
  logic [1:0]  lvl_or;
  int          nchg, first_cl2;
  logic [1:0]  exp_lv [4];

  initial begin
    // reset release: strobe phases from cycle 0
    do_reset();
    check("reset_level", level, 0);
    check("reset_chg", level_chg, 0);
    check("reset_strobes", {cl1, cl2, cl3, cl4}, 0);
    m1 = '0; m2 = '0; m3 = '0; m4 = '0; lvl_or = '0;
    for (int i = 0; i < 18; i++) begin
      if (i > 0) step();
      m1[i] = cl1; m2[i] = cl2; m3[i] = cl3; m4[i] = cl4;
      lvl_or |= level;
    end
    check("cl4_phase", m4, 18'h15554);
    check("cl3_phase", m3, 18'h11110);
    check("cl2_phase", m2, 18'h01040);
    check("cl1_phase", m1, 18'h10100);
    check("level_idle", lvl_or, 0);

    // held request: only the rising edge counts, dividers restart at cycle 11
    do_reset();
    repeat (10) step();
    level_up = 1'b1;
    step();
    check("held_level", level, 1);
    check("held_chg", level_chg, 1);
    nchg = 0;
    first_cl2 = -1;
    while (cyc < 30) begin
      step();
      nchg += int'(level_chg);
      if (cl2 && first_cl2 < 0) first_cl2 = cyc;
    end
    level_up = 1'b0;
    check("held_no_retrigger", nchg, 0);
    check("held_level_after", level, 1);
    check("held_cl2_restart", first_cl2, 17);

    // climb and saturate (or wrap)
`ifdef LEVEL_WRAP_EN
    exp_lv = '{2'd1, 2'd2, 2'd3, 2'd0};
`else
    exp_lv = '{2'd1, 2'd2, 2'd3, 2'd3};
`endif
    do_reset();
    nchg = 0;
    for (int k = 0; k < 4; k++) begin
      level_up = 1'b1;
      step();
      check($sformatf("climb_level%0d", k), level, exp_lv[k]);
      nchg += int'(level_chg);
      level_up = 1'b0;
      step();
      nchg += int'(level_chg);
    end
`ifdef LEVEL_WRAP_EN
    check("climb_chg_count", nchg, 4);
`else
    check("climb_chg_count", nchg, 3);
`endif

    // clear beats a simultaneous rising edge, and the edge is consumed
    do_reset();
    repeat (2) begin
      level_up = 1'b1; step();
      level_up = 1'b0; step();
    end
    check("clr_pre_level", level, 2);
    level_clr = 1'b1;
    level_up = 1'b1;
    step();
    check("clr_level", level, 0);
    check("clr_chg", level_chg, 1);
    level_clr = 1'b0;
    nchg = 0;
    repeat (5) begin
      step();
      nchg += int'(level_chg);
    end
    check("clr_no_refire", nchg, 0);
    check("clr_level_after", level, 0);
    level_up = 1'b0;

    // clear at level 0 leaves phases alone
    do_reset();
    m1 = '0; m3 = '0; nchg = 0;
    for (int i = 0; i < 13; i++) begin
      if (i > 0) step();
      level_clr = (i == 3);
      m1[i] = cl1; m3[i] = cl3;
      nchg += int'(level_chg);
    end
    level_clr = 1'b0;
    check("clr0_cl3_phase", m3, 18'h01110);
    check("clr0_cl1_phase", m1, 18'h00100);
    check("clr0_no_chg", nchg, 0);

    // mid-run reset at level 3 with cl4 counter at 1
    do_reset();
    repeat (2) begin
      level_up = 1'b1; step();
      level_up = 1'b0; step();
    end
    level_up = 1'b1;
    step();
    check("mid_level3", level, 3);
    check("mid_chg", level_chg, 1);
    level_up = 1'b0;
    step();
    check("mid_cl4_restart", cl4, 0);
    reset = 1'b1;
    step();
    check("mid_rst_edge1", {level, cl1, cl2, cl3, cl4, level_chg}, 0);
    reset = 1'b0;
    step();
    check("mid_rst_edge2", {level, cl1, cl2, cl3, cl4, level_chg}, 0);
    step();
    check("mid_first_cl4", cl4, 1);
    check("mid_level0", level, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
